// File: rtl/alu_pkg.sv
// Shared constants and encodings for the arbitrated ALU slice.
// Op-codes match the legacy ALU control field.
package alu_pkg;

  localparam int WIDTH_C = 64;
  localparam int OPW_C   = 4;

  typedef enum logic [3:0] {
    OP_AND   = 4'b0000,
    OP_OR    = 4'b0001,
    OP_ADD   = 4'b0010,
    OP_SUB   = 4'b0110,
    OP_PASSB = 4'b0111,
    OP_NOR   = 4'b1100
  } alu_op_e;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/ALU.sv
// Combinational 64-bit ALU shared by the arbiter.
// Undefined op-codes produce zero.
import alu_pkg::*;

module ALU #(
  parameter int WIDTH = WIDTH_C
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       C,
  output logic [WIDTH-1:0] R
);

  always_comb begin
    R = '0;
    case (C)
      OP_AND:   R = A & B;
      OP_OR:    R = A | B;
      OP_ADD:   R = A + B;
      OP_SUB:   R = A - B;
      OP_PASSB: R = B;
      OP_NOR:   R = ~(A | B);
      default:  R = '0;
    endcase
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU between two requesters,
// with a single-entry registered result buffer.
import alu_pkg::*;

module alu_arbiter #(
  parameter int WIDTH = WIDTH_C,
  parameter int OPW   = OPW_C,
  parameter int NREQ  = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [OPW-1:0]   op0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  input  logic [OPW-1:0]   op1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_id,
  output logic [WIDTH-1:0] result,
  output logic             zero
);

  buf_state_e state_q, state_d;

  logic [NREQ-2:0] ptr_q, ptr_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic id_q, id_d;
  logic zero_q, zero_d;

  logic can_accept;
  logic sel0, sel1;
  logic gnt0_c, gnt1_c;
  logic grant;

  logic [WIDTH-1:0] alu_a, alu_b, alu_r;
  logic [OPW-1:0]   alu_c;

  // sel0/sel1 are mutually exclusive by construction
  assign can_accept = (state_q == BUF_EMPTY) | res_ready;
  assign sel0 = req0 & (~req1 | ~ptr_q[0]);
  assign sel1 = req1 & (~req0 | ptr_q[0]);

  always_comb begin
    gnt0_c = 1'b0;
    gnt1_c = 1'b0;
    if (!reset && can_accept) begin
      unique case (1'b1)
        sel0:    gnt0_c = 1'b1;
        sel1:    gnt1_c = 1'b1;
        default: ;
      endcase
    end
  end

  assign grant = gnt0_c | gnt1_c;

  always_comb begin
    alu_a = a0;
    alu_b = b0;
    alu_c = op0;
    if (gnt1_c) begin
      alu_a = a1;
      alu_b = b1;
      alu_c = op1;
    end
  end

  ALU #(
    .WIDTH(WIDTH)
  ) u_alu (
    .A(alu_a),
    .B(alu_b),
    .C(alu_c),
    .R(alu_r)
  );

  always_comb begin
    ptr_d = ptr_q;
    if (gnt0_c) ptr_d = '1;
    if (gnt1_c) ptr_d = '0;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BUF_EMPTY: if (grant) state_d = BUF_FULL;
      BUF_FULL:  if (res_ready && !grant) state_d = BUF_EMPTY;
      default:   state_d = BUF_EMPTY;
    endcase
  end

  // Entry is only overwritten by a grant; draining keeps the last value
  always_comb begin
    result_d = result_q;
    id_d     = id_q;
    zero_d   = zero_q;
    if (grant) begin
      result_d = alu_r;
      id_d     = gnt1_c;
      zero_d   = (alu_r == '0);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= BUF_EMPTY;
      ptr_q    <= '0;
      result_q <= '0;
      id_q     <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      result_q <= result_d;
      id_q     <= id_d;
      zero_q   <= zero_d;
    end
  end

  always_comb begin
    gnt0      = gnt0_c;
    gnt1      = gnt1_c;
    res_valid = (state_q == BUF_FULL);
    res_id    = id_q;
    result    = result_q;
    zero      = zero_q;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed checks of grant order, result buffer and reset.
// Expected values are hand-computed.
module tb_alu_arbiter;

  logic        clock;
  logic        reset;
  logic        req0, req1;
  logic [63:0] a0, b0, a1, b1;
  logic [3:0]  op0, op1;
  logic        gnt0, gnt1;
  logic        res_valid, res_ready, res_id, zero;
  logic [63:0] result;

  int errors = 0;
  int checks = 0;

  alu_arbiter dut (
    .clock(clock),
    .reset(reset),
    .req0(req0),
    .a0(a0),
    .b0(b0),
    .op0(op0),
    .req1(req1),
    .a1(a1),
    .b1(b1),
    .op1(op1),
    .gnt0(gnt0),
    .gnt1(gnt1),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_id(res_id),
    .result(result),
    .zero(zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc;
    @(posedge clock);
    @(negedge clock);
  endtask

  logic       exp_g0 [3];
  logic [63:0] exp_r [3];

  initial begin
    exp_g0 = '{1'b1, 1'b0, 1'b1};
    exp_r  = '{64'd70, 64'd3, 64'd70};

    reset = 1'b1;
    req0 = 0; req1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    op0 = 0; op1 = 0;
    res_ready = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_valid", res_valid, 0);
    check("rst_result", result, 0);
    check("rst_id", res_id, 0);
    check("rst_zero", zero, 0);
    check("rst_gnt0", gnt0, 0);
    check("rst_gnt1", gnt1, 0);

    @(negedge clock);
    req0 = 1; a0 = 5; b0 = 5; op0 = 4'b0010;
    #1;
    check("t1_gnt0", gnt0, 1);
    check("t1_gnt1", gnt1, 0);
    next_cyc();
    req0 = 0;
    check("t1_valid", res_valid, 1);
    check("t1_result", result, 10);
    check("t1_id", res_id, 0);
    check("t1_zero", zero, 0);

    req1 = 1; a1 = 10; b1 = 10; op1 = 4'b0110;
    #1;
    check("t2_gnt1", gnt1, 1);
    check("t2_gnt0", gnt0, 0);
    next_cyc();
    req1 = 0;
    check("t2_valid", res_valid, 1);
    check("t2_result", result, 0);
    check("t2_zero", zero, 1);
    check("t2_id", res_id, 1);
    next_cyc();
    check("drain_valid", res_valid, 0);
    check("drain_result", result, 0);
    check("drain_id", res_id, 1);

    req0 = 1; a0 = 27; b0 = 43; op0 = 4'b0010;
    req1 = 1; a1 = 1;  b1 = 2;  op1 = 4'b0010;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("rr_gnt0", gnt0, exp_g0[i]);
      check("rr_gnt1", gnt1, !exp_g0[i]);
      next_cyc();
      check("rr_valid", res_valid, 1);
      check("rr_result", result, exp_r[i]);
      check("rr_id", res_id, !exp_g0[i]);
    end

    res_ready = 0;
    #1;
    check("bp_gnt0", gnt0, 0);
    check("bp_gnt1", gnt1, 0);
    for (int i = 0; i < 3; i++) begin
      next_cyc();
      check("bp_valid", res_valid, 1);
      check("bp_result", result, 70);
      check("bp_id", res_id, 0);
      check("bp_gnt0h", gnt0, 0);
      check("bp_gnt1h", gnt1, 0);
    end
    res_ready = 1;
    #1;
    check("bp_rel_gnt1", gnt1, 1);
    check("bp_rel_gnt0", gnt0, 0);
    next_cyc();
    check("bp_rel_result", result, 3);
    check("bp_rel_id", res_id, 1);

    req1 = 0; op0 = 4'b0110;
    #1;
    check("sub_gnt0", gnt0, 1);
    next_cyc();
    check("sub_result", result, 64'hFFFF_FFFF_FFFF_FFF0);
    check("sub_zero", zero, 0);
    check("sub_id", res_id, 0);
    op0 = 4'b0111;
    #1;
    check("passb_gnt0", gnt0, 1);
    next_cyc();
    check("passb_result", result, 43);

    req0 = 0; op0 = 4'b0010;
    req1 = 1; a1 = 1; b1 = 2;
    res_ready = 0;
    #1;
    check("pre_rst_valid", res_valid, 1);
    check("pre_rst_gnt1", gnt1, 0);
    #2;
    reset = 1;
    #1;
    check("arst_valid", res_valid, 0);
    check("arst_result", result, 0);
    check("arst_id", res_id, 0);
    check("arst_gnt1", gnt1, 0);
    @(negedge clock);
    reset = 0;
    req0 = 1;
    res_ready = 1;
    #1;
    check("post_rst_gnt0", gnt0, 1);
    check("post_rst_gnt1", gnt1, 0);
    next_cyc();
    check("post_rst_result", result, 70);
    check("post_rst_id", res_id, 0);
    check("post_rst_next_gnt1", gnt1, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one 64-bit ALU instance (module ALU: A, B, C[3:0], R) between two requesters, e.g. the execute stage and a branch/address unit. Round-robin grant, one operation per cycle max, result registered in a single-entry output buffer with valid/ready backpressure. Result tagged with requester ID plus zero flag.

Parameters:
WIDTH, 64, operand/result width (must match ALU)
OPW, 4, ALU op-code width
NREQ, 2, number of requesters (fixed at 2 for this revision)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
req0  in  1  requester 0 has an operation pending
a0  in  WIDTH  requester 0 operand A
b0  in  WIDTH  requester 0 operand B
op0  in  OPW  requester 0 ALU op-code
req1  in  1  requester 1 has an operation pending
a1  in  WIDTH  requester 1 operand A
b1  in  WIDTH  requester 1 operand B
op1  in  OPW  requester 1 ALU op-code
gnt0  out  1  requester 0 operation accepted this cycle
gnt1  out  1  requester 1 operation accepted this cycle
res_valid  out  1  output buffer holds a result
res_ready  in  1  consumer accepts result this cycle
res_id  out  1  ID of requester that produced result
result  out  WIDTH  registered ALU result
zero  out  1  result == 0

Behaviour:
- Clock port is clock, reset port is reset; reset asynchronous, active-high.
- Reset: gnt0=gnt1=0, res_valid=0, res_id=0, result=0, zero=0, priority pointer=0 (requester 0 favoured).
- Handshake in: requester holds req/a/b/op stable until it sees gntN=1 in the same cycle; transfer occurs on the edge where reqN & gntN. gnt combinational from req, pointer, buffer state; never both grants high.
- can_accept = !res_valid | res_ready. No grant when can_accept=0.
- Arbitration when can_accept: only one req -> grant it; both -> grant requester at pointer. After any grant pointer = ~granted ID (strict alternation under contention).
- Datapath: mux selects granted requester's a/b/op into ALU A/B/C; when no grant mux selects requester 0 (value ignored).
- Output buffer states EMPTY (res_valid=0), FULL (res_valid=1):
  EMPTY + grant -> FULL, load result=R, res_id, zero=(R==0).
  FULL + res_ready + grant -> FULL, load new entry (back-to-back, 1 result/cycle).
  FULL + res_ready + no grant -> EMPTY; result/res_id/zero keep last value.
  FULL + !res_ready -> FULL, contents held, no grant.
- Latency: grant cycle N -> res_valid=1 with result from cycle N+1.
- Width: result is full WIDTH ALU output; no carry/overflow flags. SUB wraps two's complement.
- Reset mid-operation: buffered result discarded, pointer to 0; requester whose req was not granted before reset must keep req asserted.
- Req deasserted without grant: allowed, nothing recorded.

Decomposition:
- Shared package alu_pkg: OPW/WIDTH constants, op-codes AND=0000, OR=0001, ADD=0010, SUB=0110, PASSB=0111, NOR=1100; buffer state encoding EMPTY/FULL.
- One sub-module: existing ALU instantiated once; arbiter logic (pointer, grant, buffer FSM) kept in alu_arbiter, no further split.

Test Plan:
- req0 only, a0=5, b0=5, op0=0010, res_ready=1 -> gnt0=1 cycle N; cycle N+1 res_valid=1, result=10, res_id=0, zero=0.
- req1 only, a1=10, b1=10, op1=0110 -> gnt1=1; next cycle result=0, zero=1, res_id=1.
- Both req held after reset, res_ready=1, op=0010, (27,43)/(1,2) -> gnt0 then gnt1 then gnt0 alternating; results 70 id0, 3 id1, 70 id0 on consecutive cycles.
- res_ready=0 with result valid, both req asserted -> no gnt, result/res_id held 3 cycles; res_ready=1 -> same-cycle grant, new result next cycle.
- a0=27, b0=43, op0=0110 -> result=64'hFFFF_FFFF_FFFF_FFF0, zero=0; op0=0111 -> result=43.
- Assert reset while res_valid=1 and req1 pending -> res_valid=0, result=0 immediately (async); after release with both req, gnt0 first.
